// File: rtl/division_pkg.sv
`default_nettype none
// ============================================================================
// Module   : division_pkg
// Desc     : Shared types and helpers for the divider / reconstructor pair.
// Revision : 1.0 - initial release
// ============================================================================
package division_pkg;

   localparam int DIV_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ADD  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Iteration counter width; never narrower than one bit.
   function automatic int count_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage
`default_nettype wire

// File: rtl/shift_add_datapath.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_datapath
// Desc     : Shift-add multiplier with final remainder add and dividend compare.
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_datapath #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_load,
   input  logic               i_step,
   input  logic               i_finish,
   input  logic [WIDTH-1:0]   i_multiplicand,
   input  logic [WIDTH-1:0]   i_multiplier,
   input  logic [WIDTH:0]     i_addend,
   input  logic [WIDTH-1:0]   i_expected,
   output logic [2*WIDTH:0]   o_product,
   output logic               o_match
);

   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH:0]   r_q, r_d;
   logic [WIDTH-1:0] e_q, e_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH:0] product_q, product_d;
   logic             match_q, match_d;

   logic [WIDTH:0]   w_partial;
   logic [2*WIDTH:0] w_sum;

   always_comb begin
      // w_partial[WIDTH] is the carry; it is shifted into the accumulator MSB.
      w_partial = {1'b0, acc_q} + ({(WIDTH+1){q_q[0]}} & {1'b0, m_q});
      w_sum     = {1'b0, acc_q, q_q} + {{WIDTH{1'b0}}, r_q};

      m_d       = m_q;
      q_d       = q_q;
      r_d       = r_q;
      e_d       = e_q;
      acc_d     = acc_q;
      product_d = product_q;
      match_d   = match_q;

      if (i_load) begin
         m_d   = i_multiplicand;
         q_d   = i_multiplier;
         r_d   = i_addend;
         e_d   = i_expected;
         acc_d = '0;
      end else if (i_step) begin
         acc_d = w_partial[WIDTH:1];
         q_d   = {w_partial[0], q_q[WIDTH-1:1]};
      end else if (i_finish) begin
         product_d = w_sum;
         match_d   = (w_sum == {{(WIDTH+1){1'b0}}, e_q});
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_q       <= '0;
         q_q       <= '0;
         r_q       <= '0;
         e_q       <= '0;
         acc_q     <= '0;
         product_q <= '0;
         match_q   <= 1'b0;
      end else begin
         m_q       <= m_d;
         q_q       <= q_d;
         r_q       <= r_d;
         e_q       <= e_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         match_q   <= match_d;
      end
   end

   assign o_product = product_q;
   assign o_match   = match_q;

endmodule
`default_nettype wire

// File: rtl/division_reconstructor.sv
`default_nettype none
// ============================================================================
// Module   : division_reconstructor
// Desc     : Rebuilds quotient*divisor+remainder and compares to the dividend.
// Revision : 1.0 - initial release
// ============================================================================
module division_reconstructor
   import division_pkg::*;
#(
   parameter  int WIDTH = DIV_WIDTH,
   localparam int CW    = count_width(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   input  logic [WIDTH:0]     addend,
   input  logic [WIDTH-1:0]   expected,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH:0]   product,
   output logic               match,
   output logic [CW-1:0]      count
);

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          w_load, w_step, w_finish;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      w_load   = 1'b0;
      w_step   = 1'b0;
      w_finish = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = MUL;
               count_d = '0;
               w_load  = 1'b1;
            end
         end
         MUL: begin
            w_step = 1'b1;
            if (count_q == CW'(WIDTH - 1)) begin
               state_d = ADD;
               count_d = '0;
            end else begin
               count_d = count_q + CW'(1);
            end
         end
         ADD: begin
            w_finish = 1'b1;
            state_d  = DONE;
         end
         DONE: begin
            // Start held through DONE chains straight into the next operation.
            if (start) begin
               state_d = MUL;
               count_d = '0;
               w_load  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

   shift_add_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .clk            (clk),
      .rst            (rst),
      .i_load         (w_load),
      .i_step         (w_step),
      .i_finish       (w_finish),
      .i_multiplicand (multiplicand),
      .i_multiplier   (multiplier),
      .i_addend       (addend),
      .i_expected     (expected),
      .o_product      (product),
      .o_match        (match)
   );

   assign busy  = (state_q == MUL) || (state_q == ADD);
   assign done  = (state_q == DONE);
   assign count = count_q;

endmodule
`default_nettype wire

// File: doc/division_reconstructor.md
# division_reconstructor

Sequential shift-add multiply-accumulate unit that rebuilds a dividend from a divider's results: product = multiplier × multiplicand + addend. It sits downstream of the non-restoring divider as its inverse operation and self-checker. Quotient feeds `multiplier`, divisor feeds `multiplicand`, remainder feeds `addend`. It raises `match` when the rebuilt value equals the original dividend.

## Interface
- `WIDTH`, default 4: operand width W. Must be at least 2.
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request. Sampled only in IDLE or DONE.
- `multiplicand`  in  W  unsigned (divisor).
- `multiplier`  in  W  unsigned (quotient).
- `addend`  in  W+1  unsigned (remainder). Bit W is a magnitude bit, not a sign bit.
- `expected`  in  W  unsigned reference dividend. Sampled together with the operands.
- `busy`  out  1  high in MUL and ADD.
- `done`  out  1  one-cycle pulse in DONE.
- `product`  out  2W+1  result register.
- `match`  out  1  product == zero-extended expected. Registered, valid while done=1 and held afterwards.
- `count`  out  clog2(W)  current MUL iteration index.

## Operation
- States: IDLE, MUL, ADD, DONE.
  - IDLE: on start, go to MUL.
  - MUL: stay while count != W-1, incrementing count each cycle. At W-1 go to ADD.
  - ADD: go to DONE.
  - DONE: on start, go to MUL; otherwise go to IDLE.
- Accepting start (edge in IDLE or DONE):
  - Latch M = multiplicand, Q = multiplier, R = addend, E = expected.
  - Clear the accumulator and count.
- MUL step: if Q[0]=1, add M into the upper accumulator half. Then shift {carry, acc, Q} right by one.
- After W steps, the accumulator holds M×Q exactly in 2W bits. The carry must be preserved; no truncation.
- ADD: product <= {0, acc} + zero-extended R, computed at 2W+1 bits.
- Overflow cannot occur: the maximum is (2^W−1)² + 2^(W+1)−1 = 2^(2W), which fits in 2W+1 bits.
- match is computed at the ADD edge against E and registered with product.
- start in MUL or ADD is ignored. The operation in flight completes unchanged.
- Operand inputs are don't-care except at the accept edge.
- product and match hold their values until the ADD edge of the next operation.

## Timing
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, product=0, match=0, count=0.
  - All internal registers are cleared.
- Reset asserted mid-MUL or mid-ADD aborts the operation. No done pulse is produced.
- Latency, with start accepted at edge k:
  - busy=1 after edges k … k+W.
  - ADD occupies the cycle after edge k+W.
  - product, match and done are valid after edge k+W+1, with done=1 for exactly one cycle.
- Total is W+2 cycles from the accept edge to done, i.e. 6 cycles for W=4.
- Back-to-back operation: start held high during DONE begins a new operation. Throughput is one result per W+2 cycles.
- count holds 0 outside MUL.
- During ADD and DONE, busy and done are never both high.

## Structure
- Shared package `division_pkg`:
  - state enum (IDLE=2'd0, MUL=2'd1, ADD=2'd2, DONE=2'd3)
  - `DIV_WIDTH` = 4 default
  - helper function for the count width (clog2)
- One natural sub-module, `shift_add_datapath`:
  - holds M, Q, R, E, the accumulator, the carry, and the product/match registers
  - has load, step and finish controls
- The top level holds the FSM and the counter. This mirrors the team's datapath/controller split.

## Test plan
- W=4, multiplicand=4, multiplier=3, addend=1, expected=13 → after 6 cycles product=13, match=1, single done pulse.
- multiplicand=15, multiplier=15, addend=31, expected=0 → product=256 (9'h100), match=0. Checks carry handling and no wrap.
- multiplier=0, multiplicand=9, addend=5, expected=5 → product=5, match=1. Then start is held through DONE, so a second operation (7×2+0, expected=14) gives product=14 exactly 6 cycles later.
- start pulsed and operands changed during MUL → ignored; the first result is unaffected; busy stays high for exactly W+1 cycles.
- rst driven low asynchronously, mid-clock, during MUL count=2 → all outputs 0 immediately. No done pulse follows. After release, a fresh start completes normally.
- Exhaustive sweep of all divider outputs for W=4 (dividend 0–15, divisor 1–15) → match=1 for every case.
